// File: rtl/msk_rnd_lfsr_bank_if.sv
// Seed-load and randomness-delivery bundle for the LFSR bank.
// The bank sits on the slave side; the seeder/consumer sits on the master side.
interface msk_rnd_lfsr_bank_if #(
    parameter int RND = 2
);
    logic [31:0]    seed_in;
    logic           seed_valid;
    logic           seed_ready;
    logic           reseed;
    logic           en;
    logic [RND-1:0] rnd_out;
    logic           rnd_valid;

    modport master (
        output seed_in, seed_valid, reseed, en,
        input  seed_ready, rnd_out, rnd_valid
    );

    modport slave (
        input  seed_in, seed_valid, reseed, en,
        output seed_ready, rnd_out, rnd_valid
    );
endinterface

// File: rtl/msk_rnd_lfsr_bank.sv
// Bank of 31-bit Fibonacci LFSRs (x^31+x^28+1) feeding fresh randomness
// to a masked gadget; lanes are seeded word-by-word, warmed up, then run.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_rnd_lfsr_bank #(
    parameter int d      = `DEFAULTSHARES,
    parameter int WARMUP = 64
) (
    input  logic               clk,
    input  logic               rst,
    msk_rnd_lfsr_bank_if.slave bus
);
    localparam int RND = d * (d - 1);
    localparam int CW  = (RND > 1) ? $clog2(RND) : 1;
    localparam int WW  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    typedef enum logic [1:0] {
        LOAD,
        WARM,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] warm_q, warm_d;
    logic [30:0]   lane_q [RND];
    logic [30:0]   lane_d [RND];

    logic          accept;
    logic          step;
    logic [30:0]   seed_w;
    logic          seed_unused;

    // Bit 31 of each seed word carries nothing into the 31-bit lanes.
    assign seed_unused = bus.seed_in[31];

    always_comb begin
        accept = (state_q == LOAD) && bus.seed_valid;
        step   = (state_q == WARM) || ((state_q == RUN) && bus.en);
        seed_w = (bus.seed_in[30:0] == 31'd0) ? 31'h1 : bus.seed_in[30:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    if (cnt_q == CW'(RND - 1)) begin
                        cnt_d   = '0;
                        state_d = (WARMUP == 0) ? RUN : WARM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WARM: begin
                if (warm_q == WW'(WARMUP - 1)) begin
                    warm_d  = '0;
                    state_d = RUN;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            RUN: begin
                if (bus.reseed) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // Loading and stepping are mutually exclusive: lanes never step in LOAD.
    always_comb begin
        for (int k = 0; k < RND; k++) begin
            lane_d[k] = lane_q[k];
            if (step) begin
                lane_d[k] = {lane_q[k][29:0], lane_q[k][30] ^ lane_q[k][27]};
            end
            if (accept && (cnt_q == CW'(k))) begin
                lane_d[k] = seed_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            warm_q  <= '0;
            for (int k = 0; k < RND; k++) begin
                lane_q[k] <= 31'h1;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
            for (int k = 0; k < RND; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < RND; k++) begin
            bus.rnd_out[k] = lane_q[k][0];
        end
    end

    assign bus.seed_ready = (state_q == LOAD);
    assign bus.rnd_valid  = (state_q == RUN);

endmodule

// File: doc/msk_rnd_lfsr_bank.md
Name: msk_rnd_lfsr_bank

Overview:
- Fresh-randomness source for masked gadgets.
- Sits directly upstream of the HPC3 masked AND and drives its rnd input with d*(d-1) fresh bits every enabled cycle.
- Uses one 31-bit Fibonacci LFSR lane per output bit. Lanes are seeded word-by-word over a valid/ready handshake, then warmed up before output is declared valid.
- Supports reseeding at run time without a reset.

Parameters:
- d, `DEFAULTSHARES (2), number of shares of the consuming gadget.
- RND, d*(d-1) (localparam, not overridable), number of output bits and lanes.
- WARMUP, 64, free-running steps after seeding before rnd_valid rises; 0 allowed.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_in  in  32  seed word for the lane currently being loaded.
- seed_valid  in  1  seed_in is valid.
- seed_ready  out  1  block accepts a seed word this cycle.
- reseed  in  1  single-cycle request to restart seeding; honoured in RUN only.
- en  in  1  advance all lanes one step (consumer took rnd_out).
- rnd_out  out  RND  random bits; bit k = bit 0 of lane k.
- rnd_valid  out  1  rnd_out is usable.

Behaviour:
- Lane k: 31-bit register s_k. Step: fb = s_k[30] ^ s_k[27] (x^31+x^28+1); s_k <= {s_k[29:0], fb}.
- rnd_out[k] = s_k[0]. It is read straight from the lane register, with no extra register stage.
- Reset (rst=1 at an edge): state=LOAD, word counter=0, warm counter=0, all lanes=31'h1, seed_ready=1, rnd_valid=0. Reset mid-operation (any state) discards all progress, including a partial seed load.
- FSM states:
  - LOAD: seed_ready=1, rnd_valid=0, lanes do not step.
    - On each seed_valid&&seed_ready, lane[cnt] <= seed_in[30:0], or 31'h1 if seed_in[30:0]==0 (an all-zero lane is forbidden). seed_in[31] is ignored.
    - After each accepted word, cnt++.
    - When the word with cnt==RND-1 is accepted, go to WARM (to RUN directly if WARMUP==0), and reset cnt to 0.
  - WARM: seed_ready=0, rnd_valid=0. All lanes step every cycle regardless of en. After exactly WARMUP steps, go to RUN.
  - RUN: seed_ready=0, rnd_valid=1.
    - Lanes step on each cycle with en=1 and hold when en=0.
    - reseed=1 goes to LOAD next cycle, with rnd_valid=0 from that cycle; lanes keep their values until overwritten.
    - reseed and en in the same cycle: the step is performed and the transition to LOAD is still taken.
- reseed outside RUN is ignored. en outside RUN is ignored.
- seed_valid in WARM/RUN is ignored; no word is consumed.
- rnd_valid changes only on state transitions. The first valid value is the lane state after WARMUP steps.
- Latency:
  - Seed to valid: RND accepted words + WARMUP cycles. rnd_valid rises the cycle after the last warm step.
  - en to new value: 1 cycle.
- The bank is not a cryptographic PRNG. Lane outputs are independent only if seeds are independent; supplying independent seeds is the integrator's responsibility.
- No combinational path from any input to any output.

Test Plan:
- Reset/defaults: assert rst 2 cycles → seed_ready=1, rnd_valid=0, rnd_out=all ones (lanes=1). Then hold rst high during WARM → back to LOAD with cnt=0.
- Seed and first step, d=2, WARMUP=0: load words 0x00000001, 0x40000000 → next cycle rnd_valid=1, rnd_out=2'b01. Pulse en → rnd_out=2'b10 (lane0=0x2, lane1=0x00000001).
- Zero seed guard: load 0x00000000 and 0x80000000 (bit 31 ignored, so zero) → both lanes 31'h1, rnd_out=2'b11 at RUN entry.
- Warm-up count, WARMUP=64: rnd_valid stays 0 for exactly 64 cycles after the last seed word, and rises on cycle 65. Lane states match a software model advanced 64 steps. en toggling during WARM has no effect.
- Hold/step in RUN: en low 10 cycles → rnd_out constant. 1000 en pulses → sequence matches software model bit-exact. Seed_valid pulses during RUN consume nothing (seed_ready=0).
- Reseed: in RUN, assert reseed with en=1 → one step applied, then LOAD and rnd_valid=0 next cycle. Reload new seeds → RUN with outputs matching the new seeds.
